// File: rtl/synth_audio_pkg.sv
// Shared definitions for the synth audio path: sample/FIFO widths, the
// frame scheduler state encoding and the 24-bit saturation helper.
package synth_audio_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int FIFO_W    = 32;
  localparam int PAD_W     = FIFO_W - SAMPLE_W;
  // Widest accumulator we ever saturate: 24 bits plus headroom for 32 voices.
  localparam int ACC_MAX_W = SAMPLE_W + 6;

  localparam logic signed [ACC_MAX_W-1:0] SAT_MAX = ACC_MAX_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_MAX_W-1:0] SAT_MIN = ACC_MAX_W'(-(2 ** (SAMPLE_W - 1)));

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WAIT,
    WR_L,
    WR_R
  } state_t;

  function automatic logic [SAMPLE_W-1:0] sat24(input logic signed [ACC_MAX_W-1:0] acc);
    if (acc > SAT_MAX) begin
      return 24'h7FFFFF;
    end else if (acc < SAT_MIN) begin
      return 24'h800000;
    end else begin
      return acc[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/voice_frame_scheduler_sat_accum.sv
// Signed accumulator with synchronous clear/add and a saturated 24-bit view
// of the running sum; one instance per stereo channel.
module sat_accum
  import synth_audio_pkg::*;
#(
  parameter int ACC_W = SAMPLE_W + 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_add,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic        [SAMPLE_W-1:0] o_sat
);

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     w_sampleExt;
  logic signed [ACC_MAX_W-1:0] w_accExt;

  assign w_sampleExt = {{(ACC_W - SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_accExt    = {{(ACC_MAX_W - ACC_W){r_acc[ACC_W-1]}}, r_acc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + w_sampleExt;
    end
  end

  assign o_sat = sat24(w_accExt);

endmodule

// File: rtl/voice_frame_scheduler.sv
// Per-sample-period scheduler: polls enabled voices via req/ack, sums the stereo
// samples with saturation and writes a left then right word into the TX FIFO.
module voice_frame_scheduler
  import synth_audio_pkg::*;
#(
  parameter int NUM_VOICES    = 8,
  parameter int VOICE_TIMEOUT = 63
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [NUM_VOICES-1:0]         voice_enable,
  output logic                          voice_req,
  output logic [$clog2(NUM_VOICES)-1:0] voice_idx,
  input  logic                          voice_ack,
  input  logic [SAMPLE_W-1:0]           voice_l,
  input  logic [SAMPLE_W-1:0]           voice_r,
  output logic                          fifo_wrreq,
  input  logic                          fifo_full,
  output logic [FIFO_W-1:0]             fifo_data,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int CNT_W = $clog2(VOICE_TIMEOUT + 1);

  state_t                r_state;
  logic [NUM_VOICES-1:0] r_enable;
  // One extra bit so the index can reach NUM_VOICES and mark the end of the scan.
  logic [IDX_W:0]        r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_req;
  logic                  r_wrreq;
  logic [FIFO_W-1:0]     r_fifoData;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_timeoutErr;

  logic                  w_accClr;
  logic                  w_accAdd;
  logic [SAMPLE_W-1:0]   w_satL;
  logic [SAMPLE_W-1:0]   w_satR;

  assign w_accClr = (r_state == IDLE) && frame_tick;
  assign w_accAdd = (r_state == WAIT) && voice_ack;

  sat_accum #(.ACC_W(ACC_W)) u_accL (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_accClr),
    .i_add    (w_accAdd),
    .i_sample (voice_l),
    .o_sat    (w_satL)
  );

  sat_accum #(.ACC_W(ACC_W)) u_accR (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_accClr),
    .i_add    (w_accAdd),
    .i_sample (voice_r),
    .o_sat    (w_satR)
  );

  // Error sets are written after the clear so a coincident set event wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_enable     <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_wrreq      <= 1'b0;
      r_fifoData   <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_wrreq <= 1'b0;
      if (err_clr) begin
        r_overrun    <= 1'b0;
        r_timeoutErr <= 1'b0;
      end
      if (frame_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (frame_tick) begin
            r_enable <= voice_enable;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (r_idx == (IDX_W + 1)'(NUM_VOICES)) begin
            r_state <= WR_L;
          end else if (r_enable[r_idx[IDX_W-1:0]]) begin
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= WAIT;
          end else begin
            r_idx <= r_idx + (IDX_W + 1)'(1);
          end
        end
        WAIT: begin
          if (voice_ack) begin
            r_req   <= 1'b0;
            r_idx   <= r_idx + (IDX_W + 1)'(1);
            r_state <= SCAN;
          end else if (r_cnt == CNT_W'(VOICE_TIMEOUT - 1)) begin
            r_timeoutErr <= 1'b1;
            r_req        <= 1'b0;
            r_idx        <= r_idx + (IDX_W + 1)'(1);
            r_state      <= SCAN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WR_L: begin
          if (!fifo_full) begin
            r_wrreq    <= 1'b1;
            r_fifoData <= {w_satL, {PAD_W{1'b0}}};
            r_state    <= WR_R;
          end
        end
        WR_R: begin
          if (!fifo_full) begin
            r_wrreq    <= 1'b1;
            r_fifoData <= {w_satR, {PAD_W{1'b0}}};
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign voice_req   = r_req;
  assign voice_idx   = r_idx[IDX_W-1:0];
  assign fifo_wrreq  = r_wrreq;
  assign fifo_data   = r_fifoData;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeoutErr;

endmodule
